// File: rtl/aq_axil_pkg.sv
// Shared AXI4-Lite definitions: FSM state encoding, response codes and the
// default CACHE/PROT attributes used by the bridge and the slave blocks.
package aq_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RRESP = 3'd4
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

  // EXOKAY counts as success; only SLVERR/DECERR flag an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   return 1'b0;
      RESP_SLVERR, RESP_DECERR: return 1'b1;
      default:                  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/aq_axilm_bridge.sv
// AXI4-Lite master: turns single-beat pulse-request local commands into one
// outstanding AXI4-Lite read or write transaction at a time.
module aq_axilm_bridge
  import aq_axil_pkg::*;
#(
  parameter logic [3:0] C_AXI_CACHE = AXI_CACHE_DEFAULT,
  parameter logic [2:0] C_AXI_PROT  = AXI_PROT_DEFAULT
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        LOCAL_CS,
  input  logic        LOCAL_RNW,
  input  logic [31:0] LOCAL_ADDR,
  input  logic [3:0]  LOCAL_BE,
  input  logic [31:0] LOCAL_WDATA,
  output logic        LOCAL_BUSY,
  output logic        LOCAL_ACK,
  output logic [31:0] LOCAL_RDATA,
  output logic        LOCAL_ERR,
  output logic [31:0] M_AXI_AWADDR,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  input  logic [1:0]  M_AXI_BRESP,
  output logic [31:0] M_AXI_ARADDR,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  axil_state_t state;
  logic        aw_done;
  logic        w_done;

  assign M_AXI_AWCACHE = C_AXI_CACHE;
  assign M_AXI_ARCACHE = C_AXI_CACHE;
  assign M_AXI_AWPROT  = C_AXI_PROT;
  assign M_AXI_ARPROT  = C_AXI_PROT;

  // A channel is finished once its flag has dropped or is handshaking now.
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= ST_IDLE;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      LOCAL_BUSY    <= 1'b0;
      LOCAL_ACK     <= 1'b0;
      LOCAL_ERR     <= 1'b0;
      LOCAL_RDATA   <= '0;
    end else begin
      LOCAL_ACK <= 1'b0;
      case (state)
        ST_IDLE: begin
          // BUSY still covers the ACK cycle, so a request is taken one cycle later.
          if (LOCAL_BUSY) begin
            LOCAL_BUSY <= 1'b0;
          end else if (LOCAL_CS) begin
            LOCAL_BUSY <= 1'b1;
            if (LOCAL_RNW) begin
              M_AXI_ARADDR  <= LOCAL_ADDR;
              M_AXI_ARVALID <= 1'b1;
              state         <= ST_RADDR;
            end else begin
              M_AXI_AWADDR  <= LOCAL_ADDR;
              M_AXI_WDATA   <= LOCAL_WDATA;
              M_AXI_WSTRB   <= LOCAL_BE;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= ST_WADDR;
            end
          end
        end
        ST_WADDR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            LOCAL_ACK    <= 1'b1;
            LOCAL_ERR    <= resp_is_err(M_AXI_BRESP);
            state        <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= ST_RRESP;
          end
        end
        ST_RRESP: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RREADY <= 1'b0;
            LOCAL_RDATA  <= M_AXI_RDATA;
            LOCAL_ACK    <= 1'b1;
            LOCAL_ERR    <= resp_is_err(M_AXI_RRESP);
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_axilm_bridge.sv
// Directed bench for aq_axilm_bridge: cycle-exact handshake checks plus a
// scoreboard of expected completion data/error per local command.
module tb_aq_axilm_bridge;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        LOCAL_CS, LOCAL_RNW;
  logic [31:0] LOCAL_ADDR, LOCAL_WDATA;
  logic [3:0]  LOCAL_BE;
  logic        LOCAL_BUSY, LOCAL_ACK, LOCAL_ERR;
  logic [31:0] LOCAL_RDATA;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  aq_axilm_bridge dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .LOCAL_CS(LOCAL_CS), .LOCAL_RNW(LOCAL_RNW), .LOCAL_ADDR(LOCAL_ADDR),
    .LOCAL_BE(LOCAL_BE), .LOCAL_WDATA(LOCAL_WDATA), .LOCAL_BUSY(LOCAL_BUSY),
    .LOCAL_ACK(LOCAL_ACK), .LOCAL_RDATA(LOCAL_RDATA), .LOCAL_ERR(LOCAL_ERR),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWCACHE(M_AXI_AWCACHE),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARCACHE(M_AXI_ARCACHE),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata = 32'h0;
  int          vectors = 0;
  int          miscompares = 0;
  int          aw_beats = 0;
  int          w_beats = 0;
  int          ack_count = 0;

  always @(posedge ACLK) begin
    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_beats++;
    if (M_AXI_WVALID && M_AXI_WREADY)   w_beats++;
    if (LOCAL_ACK)                      ack_count++;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected completion and compare it with the ACK-cycle outputs.
  task automatic chk_completion(input string tag);
    exp_t e;
    chk({tag, "_ack"}, {31'd0, LOCAL_ACK}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, LOCAL_RDATA, e.rdata);
      chk({tag, "_err"}, {31'd0, LOCAL_ERR}, {31'd0, e.err});
      chk({tag, "_busy"}, {31'd0, LOCAL_BUSY}, 32'd1);
    end
  endtask

  // Issue one local command (one-cycle CS) and record its expected result.
  task automatic issue(input logic rnw, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [31:0] rd, input logic err);
    exp_t e;
    if (rnw) model_rdata = rd;
    e.rdata = model_rdata;
    e.err   = err;
    sb_q.push_back(e);
    LOCAL_CS = 1'b1; LOCAL_RNW = rnw; LOCAL_ADDR = a; LOCAL_BE = be; LOCAL_WDATA = d;
    tick();
    LOCAL_CS = 1'b0;
  endtask

  // Wait (bounded) for ACK after issue(); reports cycles from CS to ACK.
  task automatic wait_ack(input string tag, input int exp_lat);
    int n = 1;
    while (!LOCAL_ACK && n < 30) begin
      tick();
      n++;
    end
    if (!LOCAL_ACK) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      chk({tag, "_latency"}, n, exp_lat);
      chk_completion(tag);
    end
    tick();
  endtask

  task automatic slave_idle();
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = 32'h0;
  endtask

  initial begin
    int aw0, w0, a0;
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int aw0, w0, a0;
    ARESET = 1'b1;
    LOCAL_CS = 0; LOCAL_RNW = 0; LOCAL_ADDR = 0; LOCAL_BE = 0; LOCAL_WDATA = 0;
    slave_idle();
    tick(); tick();
    ARESET = 1'b0;

    // Reset state
    chk("rst_awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);
    chk("rst_wvalid",  {31'd0, M_AXI_WVALID},  32'd0);
    chk("rst_arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
    chk("rst_bready",  {31'd0, M_AXI_BREADY},  32'd0);
    chk("rst_rready",  {31'd0, M_AXI_RREADY},  32'd0);
    chk("rst_busy",    {31'd0, LOCAL_BUSY},    32'd0);
    chk("rst_ack",     {31'd0, LOCAL_ACK},     32'd0);
    chk("rst_err",     {31'd0, LOCAL_ERR},     32'd0);
    chk("rst_rdata",   LOCAL_RDATA,            32'd0);
    chk("rst_awaddr",  M_AXI_AWADDR,           32'd0);
    chk("awcache",     {28'd0, M_AXI_AWCACHE}, 32'h3);
    chk("arcache",     {28'd0, M_AXI_ARCACHE}, 32'h3);
    chk("awprot",      {29'd0, M_AXI_AWPROT},  32'h0);
    chk("arprot",      {29'd0, M_AXI_ARPROT},  32'h0);

    // Write, slave ready immediately
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
    aw0 = aw_beats; w0 = w_beats;
    issue(1'b0, 32'h04, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);          // now cycle 1
    chk("w1_awvalid", {31'd0, M_AXI_AWVALID}, 32'd1);
    chk("w1_wvalid",  {31'd0, M_AXI_WVALID},  32'd1);
    chk("w1_awaddr",  M_AXI_AWADDR, 32'h04);
    chk("w1_wstrb",   {28'd0, M_AXI_WSTRB}, 32'hF);
    chk("w1_wdata",   M_AXI_WDATA, 32'hDEADBEEF);
    chk("w1_busy",    {31'd0, LOCAL_BUSY}, 32'd1);
    tick();                                                          // cycle 2
    chk("w1_bready",  {31'd0, M_AXI_BREADY}, 32'd1);
    tick();                                                          // cycle 3
    chk_completion("w1");
    tick();                                                          // cycle 4
    chk("w1_busy_after", {31'd0, LOCAL_BUSY}, 32'd0);
    chk("w1_ack_after",  {31'd0, LOCAL_ACK},  32'd0);
    chk("w1_beats", aw_beats - aw0 + w_beats - w0, 2);
    slave_idle();

    // Write with skewed readies: W at cycle 1, AW at cycle 4
    aw0 = aw_beats; w0 = w_beats;
    issue(1'b0, 32'h0C, 4'h3, 32'h00C0FFEE, 32'h0, 1'b0);          // cycle 1
    M_AXI_WREADY = 1;
    chk("w2_awvalid_c1", {31'd0, M_AXI_AWVALID}, 32'd1);
    tick(); M_AXI_WREADY = 0;                                        // cycle 2
    chk("w2_wvalid_c2",  {31'd0, M_AXI_WVALID},  32'd0);
    chk("w2_awvalid_c2", {31'd0, M_AXI_AWVALID}, 32'd1);
    tick();                                                          // cycle 3
    chk("w2_awvalid_c3", {31'd0, M_AXI_AWVALID}, 32'd1);
    chk("w2_bready_c3",  {31'd0, M_AXI_BREADY},  32'd0);
    tick(); M_AXI_AWREADY = 1;                                       // cycle 4
    chk("w2_awvalid_c4", {31'd0, M_AXI_AWVALID}, 32'd1);
    chk("w2_awaddr_c4",  M_AXI_AWADDR, 32'h0C);
    tick(); M_AXI_AWREADY = 0;                                       // cycle 5
    chk("w2_awvalid_c5", {31'd0, M_AXI_AWVALID}, 32'd0);
    chk("w2_bready_c5",  {31'd0, M_AXI_BREADY},  32'd1);
    M_AXI_BVALID = 1;
    tick(); M_AXI_BVALID = 0;                                        // cycle 6
    chk_completion("w2");
    chk("w2_w_beats",  w_beats - w0, 1);
    chk("w2_aw_beats", aw_beats - aw0, 1);
    tick();

    // Read with delays: ARREADY at 3, RVALID at 6
    issue(1'b1, 32'h08, 4'h0, 32'h0, 32'h12345678, 1'b0);           // cycle 1
    chk("r1_arvalid_c1", {31'd0, M_AXI_ARVALID}, 32'd1);
    chk("r1_araddr",     M_AXI_ARADDR, 32'h08);
    tick();                                                          // cycle 2
    M_AXI_RVALID = 1; M_AXI_RDATA = 32'hFFFFFFFF;                    // early R must be ignored
    chk("r1_rready_c2",  {31'd0, M_AXI_RREADY}, 32'd0);
    tick(); M_AXI_RVALID = 0; M_AXI_ARREADY = 1;                     // cycle 3
    chk("r1_arvalid_c3", {31'd0, M_AXI_ARVALID}, 32'd1);
    tick(); M_AXI_ARREADY = 0;                                       // cycle 4
    chk("r1_arvalid_c4", {31'd0, M_AXI_ARVALID}, 32'd0);
    chk("r1_rready_c4",  {31'd0, M_AXI_RREADY},  32'd1);
    tick();                                                          // cycle 5
    tick(); M_AXI_RVALID = 1; M_AXI_RDATA = 32'h12345678;            // cycle 6
    tick(); M_AXI_RVALID = 0;                                        // cycle 7
    chk_completion("r1");
    tick();
    chk("r1_rready_after", {31'd0, M_AXI_RREADY}, 32'd0);

    // Error responses, then EXOKAY read
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_BVALID = 1; M_AXI_ARREADY = 1; M_AXI_RVALID = 1;
    M_AXI_RRESP = 2'b10; M_AXI_RDATA = 32'hAAAA5555;
    issue(1'b1, 32'h40, 4'h0, 32'h0, 32'hAAAA5555, 1'b1);
    wait_ack("rerr", 3);
    M_AXI_BRESP = 2'b11;
    issue(1'b0, 32'h44, 4'h1, 32'h11223344, 32'h0, 1'b1);
    wait_ack("werr", 3);
    M_AXI_RRESP = 2'b01; M_AXI_RDATA = 32'h0BADF00D; M_AXI_BRESP = 2'b00;
    issue(1'b1, 32'h48, 4'h0, 32'h0, 32'h0BADF00D, 1'b0);
    wait_ack("rok", 3);
    slave_idle();

    // Busy rejection, then CS on the cycle after ACK
    aw0 = aw_beats; a0 = ack_count;
    M_AXI_WREADY = 1; M_AXI_BVALID = 1;
    issue(1'b0, 32'h10, 4'hF, 32'h55AA55AA, 32'h0, 1'b0);           // cycle 1
    LOCAL_CS = 1; LOCAL_RNW = 0; LOCAL_ADDR = 32'h20;
    tick(); LOCAL_CS = 0; M_AXI_AWREADY = 1;                         // cycle 2
    chk("bz_awaddr", M_AXI_AWADDR, 32'h10);
    tick(); M_AXI_AWREADY = 0;                                       // cycle 3
    tick();                                                          // cycle 4
    chk_completion("bz");
    tick();                                                          // cycle 5
    chk("bz_busy_c5", {31'd0, LOCAL_BUSY}, 32'd0);
    chk("bz_aw_beats", aw_beats - aw0, 1);
    M_AXI_BVALID = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 1; M_AXI_RVALID = 1;
    M_AXI_RDATA = 32'hCAFE0001; M_AXI_RRESP = 2'b00;
    issue(1'b1, 32'h30, 4'h0, 32'h0, 32'hCAFE0001, 1'b0);
    chk("b2b_arvalid", {31'd0, M_AXI_ARVALID}, 32'd1);
    chk("b2b_araddr",  M_AXI_ARADDR, 32'h30);
    wait_ack("b2b", 3);
    chk("bz_ack_count", ack_count - a0, 2);
    slave_idle();

    // Reset mid-write
    a0 = ack_count;
    issue(1'b0, 32'h50, 4'hF, 32'h77777777, 32'h0, 1'b0);
    void'(sb_q.pop_back());
    chk("rm_awvalid_pre", {31'd0, M_AXI_AWVALID}, 32'd1);
    ARESET = 1;
    tick();
    ARESET = 0;
    chk("rm_awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);
    chk("rm_wvalid",  {31'd0, M_AXI_WVALID},  32'd0);
    chk("rm_bready",  {31'd0, M_AXI_BREADY},  32'd0);
    chk("rm_busy",    {31'd0, LOCAL_BUSY},    32'd0);
    chk("rm_rdata",   LOCAL_RDATA, 32'd0);
    model_rdata = 32'h0;
    M_AXI_BVALID = 1; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
    tick(); tick(); tick();
    chk("rm_no_ack", ack_count - a0, 0);
    slave_idle();
    M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h600DD00D;
    issue(1'b1, 32'h60, 4'h0, 32'h0, 32'h600DD00D, 1'b0);
    wait_ack("rm_read", 3);
    slave_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
